uart_tx: RTL and testbench

Serial UART transmitter: accepts a parallel data word on a one-cycle start strobe and shifts it out on `tx` as an 8N1-style frame: start bit, DBIT data bits LSB first, stop bit. Bit timing comes from the shared baud-rate generator's `s_tick`, at 16 ticks per bit, the same tick that drives the receiver. The block sits between the interface FIFO / control logic and the board TX pin, and is the transmit counterpart of the existing UART receiver.

---
 rtl/uart_tx.sv | 127 ++++++++++++
 tb/tb_uart_tx.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// uart_tx: 8N1-style serial transmitter driven by a shared 16x baud tick.
// Sends a start bit, DBIT data bits LSB first, then a stop bit that is
// SB_TICK ticks long. The serial line comes straight from a flop, so it
// never glitches.
module uart_tx #(
    parameter int DBIT    = 8,   // data bits per frame, 1..8
    parameter int SB_TICK = 16   // ticks in the stop bit, 1..16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            tx_start,
    input  logic            s_tick,
    input  logic [DBIT-1:0] din,
    output logic            tx_done,
    output logic            tx_busy,
    output logic            tx
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    // The last tick of a full bit, of the stop bit, and the index of the
    // last data bit, all sized to the counters they are compared with.
    localparam logic [3:0] S_LAST  = 4'd15;
    localparam logic [3:0] SB_LAST = 4'(SB_TICK - 1);
    localparam logic [2:0] N_LAST  = 3'(DBIT - 1);

    logic [1:0] state_q, state_d;
    logic [3:0] s_q, s_d;       // tick count within the current bit
    logic [2:0] n_q, n_d;       // data bit index
    logic [7:0] b_q, b_d;       // shift register, bit 0 is on the line
    logic       tx_q, tx_d;     // registered line level
    logic [7:0] din_ext;

    // Zero-extend the parallel word so narrow frames shift out the same way.
    always_comb begin
        din_ext            = '0;
        din_ext[DBIT-1:0]  = din;
    end

    // Next-state, counter and line-level logic; tx_done fires on the
    // STOP->IDLE transition cycle only.
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        b_d     = b_q;
        tx_d    = 1'b1;
        tx_done = 1'b0;
        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (tx_start) begin
                    state_d = START;
                    s_d     = '0;
                    b_d     = din_ext;
                end
            end
            START: begin
                tx_d = 1'b0;
                if (s_tick) begin
                    if (s_q == S_LAST) begin
                        state_d = DATA;
                        s_d     = '0;
                        n_d     = '0;
                    end else begin
                        s_d = s_q + 4'd1;
                    end
                end
            end
            DATA: begin
                tx_d = b_q[0];
                if (s_tick) begin
                    if (s_q == S_LAST) begin
                        s_d = '0;
                        b_d = {1'b0, b_q[7:1]};
                        if (n_q == N_LAST) begin
                            state_d = STOP;
                        end else begin
                            n_d = n_q + 3'd1;
                        end
                    end else begin
                        s_d = s_q + 4'd1;
                    end
                end
            end
            STOP: begin
                tx_d = 1'b1;
                if (s_tick) begin
                    if (s_q == SB_LAST) begin
                        state_d = IDLE;
                        tx_done = 1'b1;
                    end else begin
                        s_d = s_q + 4'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset drops the frame in flight and
    // returns the line to idle-high at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            s_q     <= '0;
            n_q     <= '0;
            b_q     <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            b_q     <= b_d;
            tx_q    <= tx_d;
        end
    end

    assign tx      = tx_q;
    assign tx_busy = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: three instances (8N1, 7 data bits, 5 data bits with a
// one-tick stop bit) share clock, reset, tick and data. Stimulus pushes each
// expected word into a per-instance queue; a monitor per instance decodes
// the line tick by tick and compares against the frame the word implies.
module tb_uart_tx;

    logic       clk = 1'b0;
    logic       clk_en = 1'b0;
    logic       reset;
    logic       s_tick;
    logic [7:0] din;
    logic       start0, start1, start2;
    logic       tx0, tx1, tx2;
    logic       done0, done1, done2;
    logic       busy0, busy1, busy2;

    int compared   = 0;
    int mismatched = 0;
    int tick_mode  = 0;   // 0: every clk, 1: every 16 clk, 2: random
    int tcnt       = 0;
    int done_cnt[3];
    int exp_done[3];
    int idle_bad[3];
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic [7:0] q2[$];

    uart_tx #(.DBIT(8), .SB_TICK(16)) u8 (
        .clk(clk), .reset(reset), .tx_start(start0), .s_tick(s_tick),
        .din(din), .tx_done(done0), .tx_busy(busy0), .tx(tx0));
    uart_tx #(.DBIT(7), .SB_TICK(16)) u7 (
        .clk(clk), .reset(reset), .tx_start(start1), .s_tick(s_tick),
        .din(din[6:0]), .tx_done(done1), .tx_busy(busy1), .tx(tx1));
    uart_tx #(.DBIT(5), .SB_TICK(1)) u5 (
        .clk(clk), .reset(reset), .tx_start(start2), .s_tick(s_tick),
        .din(din[4:0]), .tx_done(done2), .tx_busy(busy2), .tx(tx2));

    initial forever begin
        #5;
        if (clk_en) clk = ~clk;
    end

    // Tick generator, changes just after the rising edge.
    initial begin
        s_tick = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            tcnt++;
            case (tick_mode)
                0:       s_tick = 1'b1;
                1:       s_tick = ((tcnt % 16) == 0);
                default: s_tick = ($urandom_range(0, 2) == 0);
            endcase
        end
    end

    function automatic int dbit_of(input int id);
        return (id == 0) ? 8 : ((id == 1) ? 7 : 5);
    endfunction

    function automatic int sb_of(input int id);
        return (id == 2) ? 1 : 16;
    endfunction

    function automatic logic get_tx(input int id);
        return (id == 0) ? tx0 : ((id == 1) ? tx1 : tx2);
    endfunction

    function automatic logic get_done(input int id);
        return (id == 0) ? done0 : ((id == 1) ? done1 : done2);
    endfunction

    function automatic logic get_busy(input int id);
        return (id == 0) ? busy0 : ((id == 1) ? busy1 : busy2);
    endfunction

    function automatic int qsize(input int id);
        return (id == 0) ? q0.size() : ((id == 1) ? q1.size() : q2.size());
    endfunction

    function automatic void push_exp(input int id, input logic [7:0] w);
        if (id == 0) q0.push_back(w);
        else if (id == 1) q1.push_back(w);
        else q2.push_back(w);
    endfunction

    function automatic logic [7:0] pop_exp(input int id);
        if (id == 0) return q0.pop_front();
        else if (id == 1) return q1.pop_front();
        else return q2.pop_front();
    endfunction

    task automatic drive_start(input int id, input logic v);
        if (id == 0) start0 = v;
        else if (id == 1) start1 = v;
        else start2 = v;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Line decoder: a frame is 16 low ticks, 16 ticks per data bit LSB
    // first, then sb high ticks; tx_done must coincide with the final tick.
    task automatic monitor(input int id);
        int         dbit, last, j, bad, bi;
        bit         in_frame, ptick, pdone, pbusy;
        logic       e;
        logic [7:0] w, got;
        dbit = dbit_of(id);
        last = 16 + 16 * dbit + sb_of(id) - 1;
        in_frame = 0; ptick = 0; pdone = 0; pbusy = 0;
        j = 0; bad = 0; w = '0; got = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                in_frame = 0;
                ptick = 0;
                pdone = 0;
                pbusy = 0;
            end else begin
                if (pdone) done_cnt[id]++;
                if (ptick) begin
                    if (!in_frame) begin
                        if (get_tx(id) == 1'b0) begin
                            check($sformatf("inst%0d frame expected", id), 32'(qsize(id) != 0), 32'd1);
                            w = (qsize(id) != 0) ? pop_exp(id) : 8'h00;
                            in_frame = 1; j = 0; bad = 0; got = '0;
                        end else begin
                            if (pbusy || pdone) idle_bad[id]++;
                        end
                    end
                    if (in_frame) begin
                        if (j < 16) e = 1'b0;
                        else if (j < 16 + 16 * dbit) e = w[(j - 16) / 16];
                        else e = 1'b1;
                        if (get_tx(id) !== e) bad++;
                        if (!pbusy) bad++;
                        if (pdone != (j == last)) bad++;
                        if (j >= 16 && j < 16 + 16 * dbit && ((j - 16) % 16) == 8) begin
                            bi = (j - 16) / 16;
                            got[bi] = get_tx(id);
                        end
                        if (j == last) begin
                            check($sformatf("inst%0d word", id), 32'(got), 32'(w));
                            check($sformatf("inst%0d frame ticks", id), 32'(bad), 32'd0);
                            in_frame = 0;
                        end
                        j++;
                    end
                end
                ptick = s_tick;
                pdone = get_done(id);
                pbusy = get_busy(id);
            end
        end
    endtask

    initial begin
        fork
            monitor(0);
            monitor(1);
            monitor(2);
        join_none
    end

    task automatic wait_idle(input int id, input int limit);
        int c = 0;
        while (get_busy(id) && c < limit) begin
            @(negedge clk);
            c++;
        end
        check($sformatf("inst%0d idle before timeout", id), 32'(get_busy(id)), 32'd0);
    endtask

    task automatic wait_done(input int id, input int limit);
        int c = 0;
        @(negedge clk);
        while (!get_done(id) && c < limit) begin
            @(negedge clk);
            c++;
        end
        check($sformatf("inst%0d done before timeout", id), 32'(get_done(id)), 32'd1);
    endtask

    // One-clk start pulse while idle; the word is expected on the line.
    task automatic send(input int id, input logic [7:0] w);
        logic [7:0] mask;
        mask = 8'hFF >> (8 - dbit_of(id));
        @(posedge clk);
        #1;
        din = w;
        drive_start(id, 1'b1);
        push_exp(id, w & mask);
        exp_done[id]++;
        @(posedge clk);
        #1;
        drive_start(id, 1'b0);
    endtask

    task automatic pulse_reject(input logic [7:0] w);
        @(posedge clk);
        #1;
        din = w;
        start0 = 1'b1;
        @(posedge clk);
        #1;
        start0 = 1'b0;
    endtask

    function automatic int pick_mode();
        if ($urandom_range(0, 5) == 0) return 1;
        return ($urandom_range(0, 1) != 0) ? 0 : 2;
    endfunction

    initial begin
        int bad;
        logic [7:0] lb[6];
        lb[0] = 8'h00; lb[1] = 8'hFF; lb[2] = 8'h55;
        lb[3] = 8'hAA; lb[4] = 8'h01; lb[5] = 8'h80;
        for (int i = 0; i < 3; i++) begin
            done_cnt[i] = 0; exp_done[i] = 0; idle_bad[i] = 0;
        end
        start0 = 0; start1 = 0; start2 = 0; din = '0;

        // Reset with no clock edges.
        reset = 1'b0;
        #1 reset = 1'b1;
        #2;
        check("reset tx", 32'(tx0), 32'd1);
        check("reset busy", 32'(busy0), 32'd0);
        check("reset done", 32'(done0), 32'd0);
        check("reset tx inst2", 32'(tx2), 32'd1);
        clk_en = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Idle line with no start.
        tick_mode = 0;
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (tx0 !== 1'b1 || tx1 !== 1'b1 || tx2 !== 1'b1) bad++;
        end
        check("idle tx high", 32'(bad), 32'd0);

        // A5 at 16 clk per tick, with starts in start bit, mid-data and done cycle.
        tick_mode = 1;
        send(0, 8'hA5);
        repeat (100) @(posedge clk);
        pulse_reject(8'h3C);
        repeat (1024) @(posedge clk);
        pulse_reject(8'h3C);
        wait_done(0, 6000);
        din = 8'h3C;
        start0 = 1'b1;
        @(posedge clk);
        #1 start0 = 1'b0;
        repeat (3000) @(posedge clk);
        check("no frame after reject", 32'(busy0), 32'd0);

        // Back-to-back with start held high.
        tick_mode = 0;
        @(posedge clk);
        #1;
        din = 8'h00;
        start0 = 1'b1;
        push_exp(0, 8'h00);
        exp_done[0]++;
        wait_done(0, 1000);
        din = 8'hFF;
        push_exp(0, 8'hFF);
        exp_done[0]++;
        @(posedge clk);
        @(posedge clk);
        #1 start0 = 1'b0;
        @(negedge clk);
        check("second frame started", 32'(busy0), 32'd1);
        wait_idle(0, 1000);

        // Reset during data bit 3 of 55.
        send(0, 8'h55);
        repeat (68) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        check("abort tx", 32'(tx0), 32'd1);
        check("abort busy", 32'(busy0), 32'd0);
        check("abort done", 32'(done0), 32'd0);
        exp_done[0]--;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        send(0, 8'h81);
        wait_idle(0, 1000);

        // Word list plus random words on every instance.
        for (int i = 0; i < 6; i++) begin
            tick_mode = pick_mode();
            send(0, lb[i]);
            wait_idle(0, 4000);
        end
        tick_mode = 2;
        send(1, 8'h5A);
        wait_idle(1, 4000);
        for (int id = 0; id < 3; id++) begin
            for (int k = 0; k < 10; k++) begin
                tick_mode = pick_mode();
                repeat ($urandom_range(0, 20)) @(posedge clk);
                send(id, 8'($urandom));
                wait_idle(id, 4000);
            end
        end

        repeat (5) @(negedge clk);
        for (int id = 0; id < 3; id++) begin
            check($sformatf("inst%0d done count", id), 32'(done_cnt[id]), 32'(exp_done[id]));
            check($sformatf("inst%0d idle ticks", id), 32'(idle_bad[id]), 32'd0);
            check($sformatf("inst%0d queue drained", id), 32'(qsize(id)), 32'd0);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
